// File: rtl/ec_pkg.sv
// ec_pkg: shared definitions for the error-correction digit path.
//   SIGN_POS / SIGN_NEG : legal sign-range comparison codes
//   ec_err_t            : per-digit fault flags {range_fault, sign_fault}
//   ec_entry_t          : buffered result entry {digit, err}
package ec_pkg;

    localparam int EC_DIGIT_W = 18;

    localparam logic [1:0] SIGN_POS = 2'd0;
    localparam logic [1:0] SIGN_NEG = 2'd2;

    typedef struct packed {
        logic range_fault;
        logic sign_fault;
    } ec_err_t;

    typedef struct packed {
        logic [EC_DIGIT_W-1:0] digit;
        ec_err_t               err;
    } ec_entry_t;

endpackage

// File: rtl/ec_skid_fifo2.sv
// ec_skid_fifo2: 2-entry valid/ready FIFO with a registered occupancy count.
//   clk, reset_n          : clock, asynchronous active-low reset
//   push_valid/push_ready : write handshake (push_ready = not full)
//   push_data             : write data
//   pop_valid/pop_ready   : read handshake (pop_valid = not empty)
//   pop_data              : head entry
// Both handshake outputs depend only on the occupancy register, so there is
// no combinational path from push_valid to pop_valid.
module ec_skid_fifo2 #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data
);

    logic [1:0]   occ;
    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic         push;
    logic         pop;

    assign push_ready = (occ != 2'd2);
    assign pop_valid  = (occ != 2'd0);
    assign push       = push_valid && push_ready;
    assign pop        = pop_valid && pop_ready;
    assign pop_data   = head_q;

    // Head is always entry 0; a pop from full shifts the tail forward.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ    <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case (occ)
                2'd0: begin
                    if (push) begin
                        head_q <= push_data;
                        occ    <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_q <= push_data;
                    end else if (push) begin
                        tail_q <= push_data;
                        occ    <= 2'd2;
                    end else if (pop) begin
                        occ    <= 2'd0;
                    end
                end
                default: begin
                    // Full: push_ready is low, so only a pop can occur.
                    if (pop) begin
                        head_q <= tail_q;
                        occ    <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/ec_digit_select.sv
// ec_digit_select: selects the final residue digit from the uncorrected and
// corrected candidates, flags sign-code inconsistency and out-of-range
// digits, counts errored bundles and buffers results in a 2-entry FIFO.
//   clk, reset_n            : clock, asynchronous active-low reset
//   in_valid/in_ready       : upstream handshake
//   sign_in_A, sign_in_B    : positive/negative range comparison codes
//   Y_in, cor_in            : uncorrected / corrected digit
//   out_valid/out_ready     : downstream handshake
//   dig_out, err_out        : selected digit, {range_fault, sign_fault}
//   clr_count               : synchronous clear of err_count
//   err_count               : saturating count of errored accepts
module ec_digit_select
    import ec_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int MODULUS    = 78125,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            sign_in_A,
    input  logic [1:0]            sign_in_B,
    input  logic [DATA_WIDTH-1:0] Y_in,
    input  logic [DATA_WIDTH-1:0] cor_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] dig_out,
    output logic [1:0]            err_out,
    input  logic                  clr_count,
    output logic [CNT_WIDTH-1:0]  err_count
);

    localparam logic [DATA_WIDTH:0] MOD_EXT = (DATA_WIDTH+1)'(MODULUS);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic                  accept_p0;
    logic [DATA_WIDTH-1:0] dig_p0;
    ec_err_t               err_p0;
    logic                  err_hit_p0;
    logic [DATA_WIDTH+1:0] head_data;

    assign accept_p0 = in_valid && in_ready;

    // Stage p0: digit selection and fault detection (combinational)
    always_comb begin
        dig_p0             = Y_in;
        err_p0             = '0;
        if (sign_in_A == SIGN_NEG && sign_in_B == SIGN_NEG) begin
            dig_p0 = cor_in;
        end else if (sign_in_A == SIGN_POS && sign_in_B == SIGN_POS) begin
            dig_p0 = Y_in;
        end else begin
            err_p0.sign_fault = 1'b1;
        end
        err_p0.range_fault = ({1'b0, dig_p0} >= MOD_EXT);
    end

    assign err_hit_p0 = accept_p0 && (err_p0.range_fault || err_p0.sign_fault);

    // Stage p1: buffered result
    ec_skid_fifo2 #(
        .W(DATA_WIDTH + 2)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  ({dig_p0, err_p0}),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (head_data)
    );

    assign dig_out = head_data[DATA_WIDTH+1:2];
    assign err_out = head_data[1:0];

    // A clear coinciding with an errored accept counts that accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (clr_count) begin
            err_count <= err_hit_p0 ? CNT_WIDTH'(1) : '0;
        end else if (err_hit_p0) begin
            err_count <= sat_inc(err_count);
        end
    end

endmodule

// File: tb/tb_ec_digit_select.sv
module tb_ec_digit_select;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sign_in_A;
    logic [1:0]  sign_in_B;
    logic [17:0] Y_in;
    logic [17:0] cor_in;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] dig_out;
    logic [1:0]  err_out;
    logic        clr_count;
    logic [15:0] err_count;

    int n_checks = 0;
    int n_errors = 0;

    ec_digit_select #(
        .DATA_WIDTH(18),
        .MODULUS   (78125),
        .CNT_WIDTH (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in_A (sign_in_A),
        .sign_in_B (sign_in_B),
        .Y_in      (Y_in),
        .cor_in    (cor_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dig_out   (dig_out),
        .err_out   (err_out),
        .clr_count (clr_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] a, input logic [1:0] b,
                         input logic [17:0] y, input logic [17:0] c);
        in_valid  = 1'b1;
        sign_in_A = a;
        sign_in_B = b;
        Y_in      = y;
        cor_in    = c;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        sign_in_A = 2'd0;
        sign_in_B = 2'd0;
        Y_in      = '0;
        cor_in    = '0;
        out_ready = 1'b1;
        clr_count = 1'b0;

        // Reset state
        #22;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dig_out",   dig_out,   0);
        chk("rst_err_out",   err_out,   0);
        chk("rst_err_count", err_count, 0);
        reset_n = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 1);

        // Back-to-back, no backpressure
        drive(2'd2, 2'd2, 18'd5, 18'd7353);
        tick();
        chk("neg_valid", out_valid, 1);
        chk("neg_dig",   dig_out,   7353);
        chk("neg_err",   err_out,   0);
        drive(2'd0, 2'd0, 18'd100, 18'd0);
        tick();
        chk("pos_valid", out_valid, 1);
        chk("pos_dig",   dig_out,   100);
        chk("pos_err",   err_out,   0);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", out_valid, 0);
        chk("clean_count", err_count, 0);

        // Sign faults
        drive(2'd2, 2'd0, 18'd9, 18'd7357);
        tick();
        chk("mix_dig",   dig_out,   9);
        chk("mix_err",   err_out,   1);
        chk("mix_count", err_count, 1);
        drive(2'd3, 2'd3, 18'd9, 18'd7357);
        tick();
        chk("ill_dig",   dig_out,   9);
        chk("ill_err",   err_out,   1);
        chk("ill_count", err_count, 2);

        // Range boundary
        drive(2'd0, 2'd0, 18'd78125, 18'd0);
        tick();
        chk("rng_hi_dig",   dig_out,   78125);
        chk("rng_hi_err",   err_out,   2);
        chk("rng_hi_count", err_count, 3);
        drive(2'd0, 2'd0, 18'd78124, 18'd0);
        tick();
        chk("rng_ok_err",   err_out,   0);
        chk("rng_ok_count", err_count, 3);
        drive(2'd2, 2'd2, 18'd1, 18'd262143);
        tick();
        chk("rng_cor_dig", dig_out,   262143);
        chk("rng_cor_err", err_out,   2);
        chk("rng_cor_cnt", err_count, 4);

        // Inputs ignored without accept
        drive(2'd2, 2'd0, 18'd262143, 18'd1);
        in_valid = 1'b0;
        tick();
        chk("idle_valid", out_valid, 0);
        chk("idle_count", err_count, 4);

        // Backpressure
        out_ready = 1'b0;
        drive(2'd0, 2'd0, 18'd11, 18'd0);
        tick();
        chk("bp1_valid", out_valid, 1);
        chk("bp1_dig",   dig_out,   11);
        chk("bp1_ready", in_ready,  1);
        drive(2'd0, 2'd0, 18'd22, 18'd0);
        tick();
        chk("bp2_ready", in_ready, 0);
        chk("bp2_dig",   dig_out,  11);
        drive(2'd0, 2'd0, 18'd33, 18'd0);
        tick();
        chk("bp3_ready", in_ready, 0);
        chk("bp3_dig",   dig_out,  11);
        out_ready = 1'b1;
        tick();
        chk("pop1_dig",   dig_out,  22);
        chk("pop1_ready", in_ready, 1);
        tick();
        chk("pop2_dig",   dig_out,   33);
        chk("pop2_valid", out_valid, 1);
        in_valid = 1'b0;
        tick();
        chk("pop3_valid", out_valid, 0);

        // Counter clear and saturation
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        chk("clr_only", err_count, 0);
        drive(2'd2, 2'd0, 18'd1, 18'd0);
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        chk("sat_reach", err_count, 65535);
        tick();
        chk("sat_hold", err_count, 65535);
        clr_count = 1'b1;
        tick();
        chk("clr_with_err", err_count, 1);
        in_valid = 1'b0;
        tick();
        clr_count = 1'b0;
        chk("clr_alone", err_count, 0);

        // Asynchronous reset with a full buffer
        out_ready = 1'b0;
        drive(2'd1, 2'd0, 18'd44, 18'd0);
        tick();
        drive(2'd0, 2'd2, 18'd55, 18'd0);
        tick();
        in_valid = 1'b0;
        chk("pre_rst_full",  in_ready,  0);
        chk("pre_rst_count", err_count, 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_count", err_count, 0);
        chk("arst_dig",   dig_out,   0);
        #10;
        reset_n = 1'b1;
        tick();
        chk("post_rst_ready", in_ready,  1);
        chk("post_rst_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ec_digit_select.md
# ec_digit_select

Digit selection and sign-consistency check stage that sits directly downstream of the negative-digit correction stage in each residue lane of the TPU error-correction path. Each cycle it accepts one uncorrected digit, one corrected digit and the two redundant sign-range comparison codes. It selects the final digit, flags inconsistent comparisons or out-of-range digits, and counts errors. Results go to the bus switch through a 2-entry valid/ready buffer that absorbs backpressure.

## Interface
- DATA_WIDTH, 18, digit width in bits
- MODULUS, 78125, lane modulus; a legal digit is less than MODULUS
- CNT_WIDTH, 16, width of the saturating error counter
- clk  input  1  single clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream digit/sign bundle valid
- in_ready  output  1  stage can accept a bundle this cycle
- sign_in_A  input  2  positive-range comparison code
- sign_in_B  input  2  negative-range comparison code
- Y_in  input  DATA_WIDTH  uncorrected digit
- cor_in  input  DATA_WIDTH  corrected digit
- out_valid  output  1  dig_out/err_out valid
- out_ready  input  1  downstream accepts this cycle
- dig_out  output  DATA_WIDTH  selected digit
- err_out  output  2  bit0 = sign fault, bit1 = range fault
- clr_count  input  1  synchronous clear of err_count
- err_count  output  CNT_WIDTH  saturating count of accepted bundles with err_out != 0

## Operation
- Sign codes are 2'd0 = POS and 2'd2 = NEG. Codes 2'd1 and 2'd3 are ILLEGAL.
- Accept happens when in_valid && in_ready.
- Selection on accept:
  - A == NEG and B == NEG: pick cor_in.
  - A == POS and B == POS: pick Y_in.
  - Any other combination (A != B, or any ILLEGAL code): pick Y_in and set bit0.
- Range check on the picked digit: if digit >= MODULUS, set bit1. The digit passes through unchanged. Compare at DATA_WIDTH+1 bits, zero-extended.
- Each accepted bundle pushes {digit, err} into a 2-entry FIFO with registered occupancy occ in 0..2.
- dig_out and err_out come from the FIFO head. out_valid = (occ != 0).
- A pop happens when out_valid && out_ready.
- in_ready = (occ != 2). Push and pop in the same cycle leave occ unchanged; order is preserved.
- err_count:
  - Increments by 1 on an accept whose err != 0, and saturates at all-ones.
  - If clr_count and an errored accept occur in the same cycle, the result is 1.
  - clr_count alone gives 0.
- Inputs are ignored whenever no accept occurs, regardless of their values.

## Timing
- Reset values: occ = 0, out_valid = 0, dig_out = 0, err_out = 0, err_count = 0. in_ready = 1 from the first cycle after reset deasserts.
- Latency: a bundle accepted at edge t is on dig_out/err_out with out_valid = 1 in the cycle after edge t.
- Throughput: 1 bundle/cycle while out_ready is held high.
- With out_ready low, two bundles are buffered, then in_ready drops in the cycle after the second accept.
- While out_valid && !out_ready, dig_out and err_out hold stable.
- After a pop from occ = 2, in_ready rises in the next cycle.
- No combinational path from in_valid to out_valid. The only combinational output paths are from registered occ.
- Reset asserted mid-stream: the FIFO empties immediately, in-flight bundles are lost, and err_count clears.

## Structure
- Shared package ec_pkg holds:
  - SIGN_POS = 2'd0 and SIGN_NEG = 2'd2 constants
  - typedef ec_err_t, a 2-bit struct {range_fault, sign_fault}
  - typedef for the FIFO entry, {digit, ec_err_t}
- One sub-module, ec_skid_fifo2: a parameterised 2-entry valid/ready FIFO with the occupancy register. It is reusable by the bus switch.
- Selection, range check and counter stay in the top module.

## Test plan
- Back-to-back bundles with out_ready = 1:
  - A = B = 2, Y = 5, cor = 7353 -> dig_out = 7353, err_out = 0.
  - A = B = 0, Y = 100 -> dig_out = 100, err_out = 0.
  - Each appears one cycle after accept, with no bubbles.
- A = 2, B = 0, Y = 9, cor = 7357 -> dig_out = 9, err_out = 2'b01, err_count = 1. Repeat with A = 3, B = 3 -> err_count = 2.
- A = B = 0, Y = 78125 -> err_out = 2'b10. Y = 78124 -> err_out = 0.
- Backpressure:
  - out_ready = 0, offer 3 bundles -> first two accepted, in_ready = 0, third held.
  - Raise out_ready -> outputs appear in order, third accepted after the first pop.
- Counter:
  - Preload 2^CNT_WIDTH-1 errors -> err_count saturates at 65535.
  - clr_count together with an errored accept -> err_count = 1.
- Reset:
  - Assert reset_n = 0 with occ = 2 -> out_valid = 0 and err_count = 0 immediately (asynchronous).
  - After release, in_ready = 1.
